// File: rtl/hci_bank_arbiter.sv
// Arbitrates N_REQ HCI requesters onto one TCDM bank port (round-robin or fixed priority),
// routes one-cycle-delayed responses by requester ID and runs the atomic test-and-set write.
module hci_bank_arbiter #(
  parameter int N_REQ = 4,
  parameter int AW    = 12,
  parameter int DW    = 32,
  parameter int BW    = 8,
  parameter int IW    = N_REQ
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    arb_policy_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*AW-1:0]     add_i,
  input  logic [N_REQ-1:0]        wen_i,
  input  logic [N_REQ*DW-1:0]     wdata_i,
  input  logic [N_REQ*DW/BW-1:0]  be_i,
  input  logic [N_REQ-1:0]        ts_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [N_REQ-1:0]        r_valid_o,
  output logic [DW-1:0]           r_rdata_o,
  output logic                    mem_req_o,
  output logic [AW-1:0]           mem_add_o,
  output logic                    mem_wen_o,
  output logic [DW-1:0]           mem_wdata_o,
  output logic [DW/BW-1:0]        mem_be_o,
  output logic [IW-1:0]           mem_id_o,
  input  logic                    mem_gnt_i,
  input  logic [DW-1:0]           mem_r_rdata_i
);

  localparam int BEW   = DW / BW;
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [0:0] {ARB, TS_WR} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   winner;
  logic [N_REQ-1:0]   valid_q, valid_d;
  logic [AW-1:0]      ts_add_q, ts_add_d;

  logic [AW-1:0]      add_arr   [N_REQ];
  logic [DW-1:0]      wdata_arr [N_REQ];
  logic [BEW-1:0]     be_arr    [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign add_arr[gi]   = add_i[gi*AW +: AW];
    assign wdata_arr[gi] = wdata_i[gi*DW +: DW];
    assign be_arr[gi]    = be_i[gi*BEW +: BEW];
  end

  // Scan candidates starting at rr_q (round-robin) or at 0 (fixed); first requester wins.
  always_comb begin
    logic             found;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (arb_policy_i) begin
        cand = IDX_W'(k);
      end else begin
        sum = {1'b0, rr_q} + (IDX_W+1)'(k);
        if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
        cand = sum[IDX_W-1:0];
      end
      if (!found && req_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    valid_d     = '0;
    ts_add_d    = ts_add_q;
    gnt_o       = '0;
    mem_req_o   = 1'b0;
    mem_add_o   = '0;
    mem_wen_o   = 1'b0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    mem_id_o    = '0;
    r_rdata_o   = mem_r_rdata_i;
    r_valid_o   = valid_q;

    case (state_q)
      ARB: begin
        if (|req_i) begin
          mem_req_o     = 1'b1;
          mem_add_o     = add_arr[winner];
          mem_wen_o     = wen_i[winner];
          mem_wdata_o   = wdata_arr[winner];
          mem_be_o      = be_arr[winner];
          mem_id_o      = IW'(1) << winner;
          gnt_o[winner] = mem_gnt_i;
          if (mem_gnt_i) begin
            rr_d    = (winner == IDX_W'(N_REQ-1)) ? '0 : winner + 1'b1;
            valid_d = N_REQ'(1) << winner;
            if (wen_i[winner] && ts_i[winner]) begin
              ts_add_d = add_arr[winner];
              state_d  = TS_WR;
            end
          end
        end
      end
      TS_WR: begin
        // Locked all-ones write: no requester sees a grant and no response is produced.
        mem_req_o   = 1'b1;
        mem_add_o   = ts_add_q;
        mem_wen_o   = 1'b0;
        mem_wdata_o = '1;
        mem_be_o    = '1;
        if (mem_gnt_i) state_d = ARB;
      end
      default: state_d = ARB;
    endcase

    // Outputs read as zero for as long as reset is held, even with requests present.
    if (!rst_ni) begin
      gnt_o       = '0;
      r_valid_o   = '0;
      r_rdata_o   = '0;
      mem_req_o   = 1'b0;
      mem_add_o   = '0;
      mem_wen_o   = 1'b0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      mem_id_o    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ARB;
      rr_q     <= '0;
      valid_q  <= '0;
      ts_add_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      valid_q  <= valid_d;
      ts_add_q <= ts_add_d;
    end
  end

endmodule

// File: doc/hci_bank_arbiter.md
Name: hci_bank_arbiter

Overview:
- Arbitrates N_REQ HCI requesters onto a single TCDM memory bank, one transfer per cycle.
- Sits between the log interconnect's per-bank request fan-in and one hci_mem_intf bank port.
- Supports round-robin or fixed-priority arbitration, per-requester response routing, and an atomic test-and-set sequence (read, then locked all-ones write).

Parameters:
N_REQ, 4, number of requesters (≥2)
AW, 12, bank word-address width
DW, 32, data width
BW, 8, bits per byte-enable lane
IW, N_REQ, response ID width (one-hot requester ID)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
arb_policy_i  in  1  0 = round-robin, 1 = fixed priority (index 0 highest)
req_i  in  N_REQ  per-requester request
add_i  in  N_REQ×AW  word address
wen_i  in  N_REQ  1 = read, 0 = write
wdata_i  in  N_REQ×DW  write data
be_i  in  N_REQ×DW/BW  byte enables
ts_i  in  N_REQ  test-and-set qualifier (meaningful only when wen_i=1)
gnt_o  out  N_REQ  per-requester grant (at most one high)
r_valid_o  out  N_REQ  per-requester response valid
r_rdata_o  out  DW  read data, broadcast to all requesters
mem_req_o  out  1  bank request
mem_add_o  out  AW  bank address
mem_wen_o  out  1  bank read/write
mem_wdata_o  out  DW  bank write data
mem_be_o  out  DW/BW  bank byte enables
mem_id_o  out  IW  one-hot ID of the current winner
mem_gnt_i  in  1  bank grant
mem_r_rdata_i  in  DW  bank read data, valid the cycle after the grant

Behaviour:
- Clocking and reset: single clock; async active-low reset.
- Reset values: all outputs are 0. rr_q = 0. State = ARB. Pending response flops are cleared.
- Reset mid test-and-set: the locked write is abandoned and no response is issued.
- ARB state, request path:
  - Winner selection is combinational from req_i.
  - Round-robin: the winner is the first requesting index at or after rr_q, wrapping modulo N_REQ.
  - Fixed priority: the winner is the lowest requesting index.
  - mem_req_o = |req_i. Address, wen, wdata, be and id are muxed from the winner.
  - gnt_o[winner] = mem_gnt_i.
- Pointer update: on a handshake (mem_req_o & mem_gnt_i), rr_q <= winner+1, wrapping N_REQ-1 → 0. rr_q also updates in fixed-priority mode. No handshake leaves rr_q unchanged.
- Response path:
  - Each handshake registers the winner ID.
  - Exactly one cycle later, r_valid_o[id] = 1 for both reads and writes.
  - r_rdata_o = mem_r_rdata_i, driven combinationally.
  - A back-to-back handshake every cycle yields r_valid every cycle.
- Test-and-set:
  - A handshake with wen=1 and ts=1 captures its address and moves the block to TS_WR.
- TS_WR state:
  - Drive mem_req_o=1, mem_wen_o=0, mem_wdata_o=all ones, mem_be_o=all ones, captured address, mem_id_o=0.
  - gnt_o = 0 for all requesters.
  - Stay in TS_WR until mem_gnt_i, then return to ARB on the next cycle.
  - The locked write produces no r_valid.
  - The read response of the TS access (old value) is issued normally one cycle after its read grant, i.e. during the first TS_WR cycle.
- Boundaries:
  - When req_i = 0, mem_req_o = 0 and mem_id_o = 0.
  - ts_i on a write is ignored.
  - arb_policy_i may change on any cycle; the new policy takes effect on that same cycle's selection.
  - mem_gnt_i low stalls: gnt_o stays 0 and inputs must be held by requesters.

Test Plan:
- Round-robin fairness: all 4 requesters held, arb_policy_i=0, mem_gnt_i=1 → grants 0,1,2,3,0 on consecutive cycles; r_valid one-hot follows one cycle later.
- Fixed priority: req_i=4'b1010, arb_policy_i=1 → requester 1 granted every cycle, requester 3 never granted while requester 1 is held.
- Bank stall: req_i[2]=1, mem_gnt_i=0 for 3 cycles, then 1 → gnt_o[2] is high only in the 4th cycle, r_valid_o[2] in the 5th, and rr_q becomes 3.
- Test-and-set: requester 0 issues a TS read at address 0x040, memory holds 0x0 → r_valid_o[0] with r_rdata 0x0. Next cycle a write of 0xFFFFFFFF to 0x040 with be=4'hF and no grants. Requester 1, requesting meanwhile, is granted only after the locked write completes.
- TS write stall: mem_gnt_i=0 for 2 cycles during TS_WR → the locked write is held stable and gnt_o stays 0 throughout.
- Reset mid-TS: rst_ni asserted in TS_WR → all outputs 0 and state ARB; after release, requester 0 is granted normally with no spurious write.
